counter_compare_n: RTL and testbench
====================================

COUNTER_COMPARE_N -- requirements
Module: counter_compare_n

Interface
REQ-001 Parameter WIDTH, default 16, bit width of counter, period and thresholds.
REQ-002 Parameter NCH, default 4, number of independent compare channels.
REQ-003 Parameter ONESHOT, default 0; 1 = stop after one full period, 0 = free-run.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  single-cycle run request.
REQ-007 stop  input  1  single-cycle halt request.
REQ-008 load  input  1  single-cycle request to stage new period/thresholds.
REQ-009 period  input  WIDTH  terminal count; the counter runs 0..period inclusive.
REQ-010 on_val  input  NCH*WIDTH  per-channel window start; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-011 off_val  input  NCH*WIDTH  per-channel window end (exclusive), same packing.
REQ-012 count  output  WIDTH  current counter value.
REQ-013 ch_out  output  NCH  registered per-channel window compare result.
REQ-014 wrap  output  1  one-cycle pulse on the cycle count returns from period to 0.
REQ-015 running  output  1  high while the FSM is in RUN.
REQ-016 load_ack  output  1  one-cycle pulse when staged values become active.

Function
REQ-017 FSM states: IDLE, RUN; the block SHALL be in no other state.
REQ-018 IDLE + start (stop low): copy period/on_val/off_val into active registers, clear the pending-load flag, set count=0, enter RUN next cycle.
REQ-019 RUN: count increments by 1 each cycle; when count==active period, next count=0 and wrap=1 in that next cycle.
REQ-020 active period=0: count held at 0; wrap asserted every cycle in RUN.
REQ-021 Unsigned arithmetic throughout; the counter never exceeds the active period and never wraps through 2^WIDTH.
REQ-022 ch_out[i] next = (count >= on_i) AND (count < off_i), using active registers; one-cycle latency behind count.
REQ-023 on_i >= off_i: ch_out[i] SHALL stay 0.
REQ-024 load (any state): capture inputs into staging registers and set the pending flag; a later load before application overwrites staging.
REQ-025 Pending staged values SHALL be copied to active registers on the cycle count goes period->0; load_ack pulses in that same cycle as wrap.
REQ-026 load on the wrap cycle itself: the new values are staged for the following wrap, not applied immediately.
REQ-027 stop in RUN: next cycle enter IDLE, count=0, ch_out=0, running=0; pending flag retained.
REQ-028 start and stop in the same cycle: stop wins; start ignored.
REQ-029 start while in RUN: ignored.
REQ-030 ONESHOT=1: on reaching count==period, return to IDLE with count=0 and wrap pulsed; ch_out=0 in IDLE.
REQ-031 In IDLE ch_out, wrap and load_ack SHALL be 0.

Reset
REQ-032 rst_n low at a clock edge: state=IDLE, count=0, ch_out=0, wrap=0, running=0, load_ack=0, pending flag=0, active and staging registers=0.
REQ-033 Reset asserted mid-RUN SHALL override start, stop and load in that cycle.

Structure
REQ-034 A shared package holds the FSM state typedef (IDLE, RUN) and the default WIDTH/NCH constants.
REQ-035 The per-channel window test is one sub-module, window_compare (WIDTH parameter, count/on/off in, registered match out), instantiated NCH times via generate.

Verification
REQ-036 WIDTH=8, NCH=2, period=9, ch0 on=2 off=5, start -> ch_out[0] high exactly for cycles following count 2,3,4; wrap every 10 cycles.
REQ-037 period=0, start -> count stays 0, wrap high every RUN cycle, running=1.
REQ-038 Running with period=9, load period=4 at count=3 -> period 9 completes; load_ack and wrap coincide; next cycle run 0..4.
REQ-039 start and stop in same IDLE cycle -> running stays 0; stop at count=6 -> count=0, ch_out=0 next cycle.
REQ-040 ch1 on=7 off=7 and on=8 off=3 -> ch_out[1] never asserts across two periods.
REQ-041 ONESHOT=1, period=5, start -> single run 0..5, one wrap pulse, then IDLE; rst_n low at count=3 in a free-run repeat -> all outputs 0 next cycle.

Source files
------------

// File: rtl/counter_compare_n_pkg.sv
// Shared types and default sizing for the counter_compare_n block.
// Holds the two-state FSM encoding used by the top level.
package counter_compare_n_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_NCH   = 4;

endpackage

// File: rtl/counter_compare_n_if.sv
// Control/compare bus of counter_compare_n: run control and load requests in, counter status out.
// No flow control; every request is a single-cycle pulse sampled on the rising edge.
interface counter_compare_n_if
    import counter_compare_n_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH
);
    logic                 start;
    logic                 stop;
    logic                 load;
    logic [WIDTH-1:0]     period;
    logic [NCH*WIDTH-1:0] on_val;
    logic [NCH*WIDTH-1:0] off_val;
    logic [WIDTH-1:0]     count;
    logic [NCH-1:0]       ch_out;
    logic                 wrap;
    logic                 running;
    logic                 load_ack;

    modport master (
        output start, stop, load, period, on_val, off_val,
        input  count, ch_out, wrap, running, load_ack
    );

    modport slave (
        input  start, stop, load, period, on_val, off_val,
        output count, ch_out, wrap, running, load_ack
    );
endinterface

// File: rtl/counter_compare_n_window_compare.sv
// One compare channel: registered (on <= count < off) test, forced low when en is low.
// Latency 1 cycle behind count; no backpressure.
module window_compare
    import counter_compare_n_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] on,
    input  logic [WIDTH-1:0] off,
    output logic             match
);

    // An empty window (on >= off) can never satisfy both bounds, so it stays low naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            match <= 1'b0;
        end else begin
            match <= en && (count >= on) && (count < off);
        end
    end

endmodule

// File: rtl/counter_compare_n.sv
// Period counter with NCH window-compare channels and shadow-loaded period/thresholds.
// Outputs registered, compare results one cycle behind count; no backpressure, requests are pulses.
module counter_compare_n
    import counter_compare_n_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NCH     = DEF_NCH,
    parameter int ONESHOT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    counter_compare_n_if.slave bus
);

    localparam bit ONE_RUN = (ONESHOT != 0);

    state_t               state;
    logic [WIDTH-1:0]     cnt;
    logic [WIDTH-1:0]     act_per;
    logic [WIDTH-1:0]     stg_per;
    logic [NCH*WIDTH-1:0] act_on;
    logic [NCH*WIDTH-1:0] act_off;
    logic [NCH*WIDTH-1:0] stg_on;
    logic [NCH*WIDTH-1:0] stg_off;
    logic                 pend;
    logic                 wrap_q;
    logic                 ack_q;
    logic [NCH-1:0]       ch;

    logic at_end;
    logic begin_run;
    logic run_go;
    logic apply;

    assign at_end    = (cnt == act_per);
    assign begin_run = (state == IDLE) && bus.start && !bus.stop;
    // run_go is true only when the next cycle is still a RUN cycle.
    assign run_go    = (state == RUN) && !bus.stop && !(ONE_RUN && at_end);
    assign apply     = (state == RUN) && !bus.stop && at_end && !ONE_RUN && pend;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            act_per <= '0;
            stg_per <= '0;
            act_on  <= '0;
            act_off <= '0;
            stg_on  <= '0;
            stg_off <= '0;
            pend    <= 1'b0;
            wrap_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            ack_q  <= 1'b0;

            if (bus.load) begin
                stg_per <= bus.period;
                stg_on  <= bus.on_val;
                stg_off <= bus.off_val;
            end

            case (state)
                IDLE: begin
                    if (begin_run) begin
                        act_per <= bus.period;
                        act_on  <= bus.on_val;
                        act_off <= bus.off_val;
                        cnt     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (at_end) begin
                        cnt    <= '0;
                        wrap_q <= 1'b1;
                        if (ONE_RUN) begin
                            state <= IDLE;
                        end else if (pend) begin
                            // Staging is read before any same-cycle load overwrites it.
                            act_per <= stg_per;
                            act_on  <= stg_on;
                            act_off <= stg_off;
                            ack_q   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (begin_run) begin
                pend <= 1'b0;
            end else if (bus.load) begin
                pend <= 1'b1;
            end else if (apply) begin
                pend <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        window_compare #(
            .WIDTH(WIDTH)
        ) u_win (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (run_go),
            .count (cnt),
            .on    (act_on[i*WIDTH +: WIDTH]),
            .off   (act_off[i*WIDTH +: WIDTH]),
            .match (ch[i])
        );
    end

    assign bus.count    = cnt;
    assign bus.ch_out   = ch;
    assign bus.wrap     = wrap_q;
    assign bus.running  = (state == RUN);
    assign bus.load_ack = ack_q;

endmodule

// File: tb/tb_counter_compare_n.sv
// Bench for counter_compare_n: free-run and one-shot instances driven in lockstep against a cycle model.
module tb_counter_compare_n;

    logic       clk;
    logic       rst_n;
    logic       start, stop, load;
    logic [7:0] period;
    logic [7:0] on_v [2];
    logic [7:0] off_v [2];

    int errors;
    int checks;

    counter_compare_n_if #(.WIDTH(8), .NCH(2)) bus0 ();
    counter_compare_n_if #(.WIDTH(8), .NCH(2)) bus1 ();

    assign bus0.start   = start;
    assign bus0.stop    = stop;
    assign bus0.load    = load;
    assign bus0.period  = period;
    assign bus0.on_val  = {on_v[1], on_v[0]};
    assign bus0.off_val = {off_v[1], off_v[0]};
    assign bus1.start   = start;
    assign bus1.stop    = stop;
    assign bus1.load    = load;
    assign bus1.period  = period;
    assign bus1.on_val  = {on_v[1], on_v[0]};
    assign bus1.off_val = {off_v[1], off_v[0]};

    counter_compare_n #(.WIDTH(8), .NCH(2), .ONESHOT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
    );
    counter_compare_n #(.WIDTH(8), .NCH(2), .ONESHOT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model, index k: 0 = free-run instance, 1 = one-shot instance.
    int m_run [2], m_cnt [2], m_per [2], s_per [2], m_pend [2];
    int m_on [2][2], m_off [2][2], s_on [2][2], s_off [2][2];
    int m_ch [2], m_wrap [2], m_ack [2];

    task automatic model_step(input int k);
        bit at_end, live, started;
        if (!rst_n) begin
            m_run[k] = 0; m_cnt[k] = 0; m_per[k] = 0; s_per[k] = 0; m_pend[k] = 0;
            m_ch[k] = 0; m_wrap[k] = 0; m_ack[k] = 0;
            for (int i = 0; i < 2; i++) begin
                m_on[k][i] = 0; m_off[k][i] = 0; s_on[k][i] = 0; s_off[k][i] = 0;
            end
            return;
        end
        at_end  = (m_cnt[k] == m_per[k]);
        live    = (m_run[k] == 1) && !stop && !(k == 1 && at_end);
        started = 0;
        m_ch[k] = 0;
        for (int i = 0; i < 2; i++)
            if (live && m_cnt[k] >= m_on[k][i] && m_cnt[k] < m_off[k][i]) m_ch[k] += (1 << i);
        m_wrap[k] = 0;
        m_ack[k]  = 0;
        if (m_run[k] == 0) begin
            if (start && !stop) begin
                m_per[k] = period;
                for (int i = 0; i < 2; i++) begin m_on[k][i] = on_v[i]; m_off[k][i] = off_v[i]; end
                m_cnt[k] = 0; m_run[k] = 1; started = 1;
            end
        end else if (stop) begin
            m_run[k] = 0; m_cnt[k] = 0;
        end else if (at_end) begin
            m_cnt[k] = 0; m_wrap[k] = 1;
            if (k == 1) m_run[k] = 0;
            else if (m_pend[k] != 0) begin
                m_per[k] = s_per[k];
                for (int i = 0; i < 2; i++) begin m_on[k][i] = s_on[k][i]; m_off[k][i] = s_off[k][i]; end
                m_pend[k] = 0; m_ack[k] = 1;
            end
        end else begin
            m_cnt[k] = m_cnt[k] + 1;
        end
        if (load) begin
            s_per[k] = period;
            for (int i = 0; i < 2; i++) begin s_on[k][i] = on_v[i]; s_off[k][i] = off_v[i]; end
            m_pend[k] = started ? 0 : 1;
        end else if (started) begin
            m_pend[k] = 0;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check("m0_count", int'(bus0.count), m_cnt[0]);
        check("m0_ch", int'(bus0.ch_out), m_ch[0]);
        check("m0_wrap", int'(bus0.wrap), m_wrap[0]);
        check("m0_running", int'(bus0.running), m_run[0]);
        check("m0_ack", int'(bus0.load_ack), m_ack[0]);
        check("m1_count", int'(bus1.count), m_cnt[1]);
        check("m1_ch", int'(bus1.ch_out), m_ch[1]);
        check("m1_wrap", int'(bus1.wrap), m_wrap[1]);
        check("m1_running", int'(bus1.running), m_run[1]);
        check("m1_ack", int'(bus1.load_ack), m_ack[1]);
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic do_reset();
        start = 1'b0; stop = 1'b0; load = 1'b0;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
    endtask

    task automatic set_win(input int per, input int on0, input int off0, input int on1, input int off1);
        period = 8'(per);
        on_v[0] = 8'(on0); off_v[0] = 8'(off0);
        on_v[1] = 8'(on1); off_v[1] = 8'(off1);
    endtask

    typedef struct {
        bit s, p, l;
        int per, on0, off0, on1, off1;
        int e_cnt, e_ch, e_wrap, e_run, e_ack;
    } vec_t;

    function automatic vec_t mk(input bit s, input bit p, input bit l, input int per,
                                input int on0, input int off0, input int on1, input int off1,
                                input int e_cnt, input int e_ch, input int e_wrap,
                                input int e_run, input int e_ack);
        vec_t v;
        v.s = s; v.p = p; v.l = l; v.per = per;
        v.on0 = on0; v.off0 = off0; v.on1 = on1; v.off1 = off1;
        v.e_cnt = e_cnt; v.e_ch = e_ch; v.e_wrap = e_wrap; v.e_run = e_run; v.e_ack = e_ack;
        return v;
    endfunction

    vec_t tab [$];
    int   wraps;

    initial begin
        errors = 0; checks = 0;
        start = 1'b0; stop = 1'b0; load = 1'b0;
        set_win(0, 0, 0, 0, 0);
        do_reset();
        check("reset_count", int'(bus0.count), 0);
        check("reset_running", int'(bus0.running), 0);
        check("reset_ch", int'(bus0.ch_out), 0);

        // Free-run instance: period 9, ch0 [2,5), ch1 empty; load at count 4 takes effect at wrap.
        tab.push_back(mk(1,0,0, 9,2,5,7,7,  0,0,0,1,0));
        tab.push_back(mk(0,0,0, 9,2,5,7,7,  1,0,0,1,0));
        tab.push_back(mk(0,0,0, 9,2,5,7,7,  2,0,0,1,0));
        tab.push_back(mk(0,0,0, 9,2,5,7,7,  3,1,0,1,0));
        tab.push_back(mk(0,0,0, 9,2,5,7,7,  4,1,0,1,0));
        tab.push_back(mk(0,0,1, 4,0,2,8,3,  5,1,0,1,0));
        tab.push_back(mk(0,0,0, 4,0,2,8,3,  6,0,0,1,0));
        tab.push_back(mk(0,0,0, 4,0,2,8,3,  7,0,0,1,0));
        tab.push_back(mk(0,0,0, 4,0,2,8,3,  8,0,0,1,0));
        tab.push_back(mk(0,0,0, 4,0,2,8,3,  9,0,0,1,0));
        tab.push_back(mk(0,0,0, 4,0,2,8,3,  0,0,1,1,1));
        tab.push_back(mk(0,0,0, 4,0,2,8,3,  1,1,0,1,0));
        tab.push_back(mk(0,0,0, 4,0,2,8,3,  2,1,0,1,0));
        tab.push_back(mk(0,0,0, 4,0,2,8,3,  3,0,0,1,0));
        tab.push_back(mk(0,0,0, 4,0,2,8,3,  4,0,0,1,0));
        tab.push_back(mk(0,0,0, 4,0,2,8,3,  0,0,1,1,0));
        tab.push_back(mk(1,1,0, 4,0,2,8,3,  0,0,0,0,0));
        tab.push_back(mk(1,1,0, 4,0,2,8,3,  0,0,0,0,0));
        foreach (tab[i]) begin
            set_win(tab[i].per, tab[i].on0, tab[i].off0, tab[i].on1, tab[i].off1);
            start = tab[i].s; stop = tab[i].p; load = tab[i].l;
            tick();
            start = 1'b0; stop = 1'b0; load = 1'b0;
            check($sformatf("tab%0d_count", i), int'(bus0.count), tab[i].e_cnt);
            check($sformatf("tab%0d_ch", i), int'(bus0.ch_out), tab[i].e_ch);
            check($sformatf("tab%0d_wrap", i), int'(bus0.wrap), tab[i].e_wrap);
            check($sformatf("tab%0d_running", i), int'(bus0.running), tab[i].e_run);
            check($sformatf("tab%0d_ack", i), int'(bus0.load_ack), tab[i].e_ack);
        end

        // Shadow load at count 3: old period finishes, ack with wrap, then 0..4.
        do_reset();
        set_win(9, 2, 5, 7, 7);
        pulse_start();
        repeat (3) tick();
        check("ld_count3", int'(bus0.count), 3);
        period = 8'd4; load = 1'b1; tick(); load = 1'b0;
        repeat (5) tick();
        check("ld_count9", int'(bus0.count), 9);
        tick();
        check("ld_wrap", int'(bus0.wrap), 1);
        check("ld_ack", int'(bus0.load_ack), 1);
        check("ld_count0", int'(bus0.count), 0);
        repeat (4) tick();
        check("ld_newmax", int'(bus0.count), 4);
        tick();
        check("ld_wrap2", int'(bus0.wrap), 1);
        check("ld_ack2", int'(bus0.load_ack), 0);

        // Zero period: counter pinned at 0, wrap every cycle once running.
        do_reset();
        set_win(0, 0, 1, 0, 0);
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("p0_count", int'(bus0.count), 0);
            check("p0_wrap", int'(bus0.wrap), 1);
            check("p0_running", int'(bus0.running), 1);
        end

        // Start+stop together is ignored; stop mid-run clears count and compare outputs.
        do_reset();
        set_win(9, 2, 5, 3, 8);
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        check("ss_running", int'(bus0.running), 0);
        pulse_start();
        repeat (6) tick();
        check("st_count6", int'(bus0.count), 6);
        check("st_ch1_hi", int'(bus0.ch_out), 2);
        stop = 1'b1; tick(); stop = 1'b0;
        check("st_count", int'(bus0.count), 0);
        check("st_ch", int'(bus0.ch_out), 0);
        check("st_running", int'(bus0.running), 0);

        // Degenerate windows never assert across two periods.
        do_reset();
        set_win(9, 2, 5, 7, 7);
        pulse_start();
        for (int i = 0; i < 20; i++) begin tick(); check("eq_ch1", int'(bus0.ch_out[1]), 0); end
        stop = 1'b1; tick(); stop = 1'b0;
        set_win(9, 2, 5, 8, 3);
        pulse_start();
        for (int i = 0; i < 20; i++) begin tick(); check("inv_ch1", int'(bus0.ch_out[1]), 0); end

        // One-shot instance: single 0..5 pass, one wrap, back to idle.
        do_reset();
        set_win(5, 1, 3, 0, 0);
        wraps = 0;
        pulse_start();
        for (int i = 0; i < 5; i++) tick();
        check("os_count5", int'(bus1.count), 5);
        check("os_running5", int'(bus1.running), 1);
        for (int i = 0; i < 8; i++) begin tick(); wraps += int'(bus1.wrap); end
        check("os_wraps", wraps, 1);
        check("os_running", int'(bus1.running), 0);
        check("os_count", int'(bus1.count), 0);

        // Reset mid-run beats start/stop/load presented in the same cycle.
        do_reset();
        set_win(9, 2, 5, 0, 9);
        pulse_start();
        repeat (3) tick();
        check("rs_count3", int'(bus0.count), 3);
        rst_n = 1'b0; start = 1'b1; stop = 1'b1; load = 1'b1;
        tick();
        rst_n = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0;
        check("rs_count", int'(bus0.count), 0);
        check("rs_ch", int'(bus0.ch_out), 0);
        check("rs_wrap", int'(bus0.wrap), 0);
        check("rs_running", int'(bus0.running), 0);
        check("rs_ack", int'(bus0.load_ack), 0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst_n  = ($urandom_range(0, 199) != 0);
            start  = ($urandom_range(0, 9) == 0);
            stop   = ($urandom_range(0, 24) == 0);
            load   = ($urandom_range(0, 11) == 0);
            set_win($urandom_range(0, 12), $urandom_range(0, 14), $urandom_range(0, 14),
                    $urandom_range(0, 14), $urandom_range(0, 14));
            tick();
        end
        rst_n = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
